// File: rtl/ctrl_pipe_reg.sv
// ---------------------------------------------------------------------------
// ctrl_pipe_reg
//   Multi-stage pipeline register for control-unit bundles (MemWrite, Branch,
//   RegWrite, ...). A WIDTH-bit control word and its valid bit travel through
//   STAGES back-to-back registers. The block supports stall (enable low) and
//   flush (every stage killed). A killed or invalid slot always carries BUBBLE,
//   so a stale control word can never act downstream.
//
//   Optional feature macro: CTRL_PIPE_STATS_EN
//     defined   -> stall_cnt / bubble_cnt are live saturating counters
//     undefined -> counter logic is absent and both outputs are tied to 0
//
// Ports
//   clk         in   1      rising-edge clock
//   rst         in   1      synchronous reset, active-high
//   enable      in   1      1 = advance all stages, 0 = hold all stages
//   flush       in   1      1 = kill every stage on this edge (beats stall)
//   valid_in    in   1      input control word is a real instruction
//   data_in     in   WIDTH  input control word
//   valid_out   out  1      last stage holds a real instruction
//   data_out    out  WIDTH  last-stage control word
//   stall_cnt   out  CNT_W  number of edges with enable=0 (saturating)
//   bubble_cnt  out  CNT_W  enabled edges that produced an invalid last stage
// ---------------------------------------------------------------------------
module ctrl_pipe_reg #(
   parameter int               WIDTH  = 8,
   parameter int               STAGES = 1,
   parameter logic [WIDTH-1:0] BUBBLE = '0,
   parameter int               CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             flush,
   input  logic             valid_in,
   input  logic [WIDTH-1:0] data_in,
   output logic             valid_out,
   output logic [WIDTH-1:0] data_out,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] bubble_cnt
);

   // Stage 0 is the entry register, stage STAGES-1 drives the outputs.
   logic             valid_q [STAGES];
   logic [WIDTH-1:0] data_q  [STAGES];

   // Value each stage takes on an advancing edge.
   logic             valid_d [STAGES];
   logic [WIDTH-1:0] data_d  [STAGES];

   genvar gi;
   generate
      for (gi = 0; gi < STAGES; gi++) begin : g_stage
         if (gi == 0) begin : g_entry
            // An invalid input is replaced by BUBBLE at the door, so garbage
            // on data_in never enters the pipe.
            assign valid_d[gi] = valid_in;
            assign data_d[gi]  = valid_in ? data_in : BUBBLE;
         end else begin : g_shift
            assign valid_d[gi] = valid_q[gi-1];
            assign data_d[gi]  = data_q[gi-1];
         end
      end
   endgenerate

   // rst and flush both empty the pipe; flush also overrides a stall.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         for (int i = 0; i < STAGES; i++) begin
            valid_q[i] <= 1'b0;
            data_q[i]  <= BUBBLE;
         end
      end else if (enable) begin
         for (int i = 0; i < STAGES; i++) begin
            valid_q[i] <= valid_d[i];
            data_q[i]  <= data_d[i];
         end
      end
   end

   assign valid_out = valid_q[STAGES-1];
   assign data_out  = data_q[STAGES-1];

`ifdef CTRL_PIPE_STATS_EN
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] bubble_cnt_q;

   // Counters saturate at all-ones and never move on a rst or flush edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else if (!flush) begin
         if (!enable) begin
            if (stall_cnt_q != '1) begin
               stall_cnt_q <= stall_cnt_q + 1'b1;
            end
         end else if (!valid_d[STAGES-1]) begin
            // The last stage is about to load an empty slot.
            if (bubble_cnt_q != '1) begin
               bubble_cnt_q <= bubble_cnt_q + 1'b1;
            end
         end
      end
   end

   assign stall_cnt  = stall_cnt_q;
   assign bubble_cnt = bubble_cnt_q;
`else
   assign stall_cnt  = '0;
   assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_ctrl_pipe_reg.sv
// ---------------------------------------------------------------------------
// tb_ctrl_pipe_reg
//   Drives two instances from the same inputs: a 3-deep pipe with 16-bit
//   counters and a 1-deep pipe with 2-bit counters (for saturation). A queue
//   model of each pipe predicts every output after every edge.
// ---------------------------------------------------------------------------
module tb_ctrl_pipe_reg;

`ifdef CTRL_PIPE_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        enable = 1'b0;
   logic        flush = 1'b0;
   logic        valid_in = 1'b0;
   logic [7:0]  data_in = 8'h00;

   logic        a_vo, b_vo;
   logic [7:0]  a_do, b_do;
   logic [15:0] a_sc, a_bc;
   logic [1:0]  b_sc, b_bc;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   ctrl_pipe_reg #(.WIDTH(8), .STAGES(3), .BUBBLE(8'h00), .CNT_W(16)) dut_a (
      .clk(clk), .rst(rst), .enable(enable), .flush(flush),
      .valid_in(valid_in), .data_in(data_in),
      .valid_out(a_vo), .data_out(a_do), .stall_cnt(a_sc), .bubble_cnt(a_bc)
   );

   ctrl_pipe_reg #(.WIDTH(8), .STAGES(1), .BUBBLE(8'h00), .CNT_W(2)) dut_b (
      .clk(clk), .rst(rst), .enable(enable), .flush(flush),
      .valid_in(valid_in), .data_in(data_in),
      .valid_out(b_vo), .data_out(b_do), .stall_cnt(b_sc), .bubble_cnt(b_bc)
   );

   logic [53:0] obs_vec;
   assign obs_vec = {a_vo, a_do, a_sc, a_bc, b_vo, b_do, b_sc, b_bc};

   // Reference model: each pipe is a FIFO of {valid,data}; an advance pushes
   // the new slot in at the front and the oldest slot falls off the back.
   // The back slot is what the DUT should show on its outputs.
   logic [8:0] qa[$];
   logic [8:0] qb[$];
   int sa, ba, sb, bb;

   function automatic logic [53:0] model_vec();
      logic [15:0] esa, eba;
      logic [1:0]  esb, ebb;
      esa = STATS ? 16'(sa) : 16'h0;
      eba = STATS ? 16'(ba) : 16'h0;
      esb = STATS ? 2'(sb) : 2'h0;
      ebb = STATS ? 2'(bb) : 2'h0;
      return {qa[2], esa, eba, qb[0], esb, ebb};
   endfunction

   // Apply one edge's inputs, advance the model, and return at the negedge.
   task automatic step(input bit r, input bit f, input bit e, input bit v,
                       input logic [7:0] d);
      logic [8:0] w;
      rst = r; flush = f; enable = e; valid_in = v; data_in = d;
      @(posedge clk);
      if (r) begin
         qa = '{9'h0, 9'h0, 9'h0};
         qb = '{9'h0};
         sa = 0; ba = 0; sb = 0; bb = 0;
      end else if (f) begin
         qa = '{9'h0, 9'h0, 9'h0};
         qb = '{9'h0};
      end else if (e) begin
         w = v ? {1'b1, d} : 9'h0;
         qa.push_front(w); void'(qa.pop_back());
         qb.push_front(w); void'(qb.pop_back());
         if (!qa[2][8]) ba = (ba < 65535) ? ba + 1 : ba;
         if (!qb[0][8]) bb = (bb < 3) ? bb + 1 : bb;
      end else begin
         sa = (sa < 65535) ? sa + 1 : sa;
         sb = (sb < 3) ? sb + 1 : sb;
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 1'b0, 1'b1, 1'b1, 8'hFF);
         n_tests++;
         if ({a_vo, a_do, a_sc, a_bc, b_vo, b_do, b_sc, b_bc} !== 54'h0) begin
            n_fail++;
            $display("FAIL reset cycle %0d: observed %h required 0", i, obs_vec);
         end
      end
   endtask

   task automatic test_latency();
      logic [7:0] words [6] = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00};
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 1'b0, 1'b1, (i < 3), words[i]);
         n_tests++;
         if (obs_vec !== model_vec()) begin
            n_fail++;
            $display("FAIL latency edge %0d: observed %h required %h", i + 1, obs_vec, model_vec());
         end
         if (i == 2) begin
            n_tests++;
            if ({a_vo, a_do} !== 9'h111) begin
               n_fail++;
               $display("FAIL latency first word: observed %b/%h required 1/11", a_vo, a_do);
            end
         end
      end
   endtask

   task automatic test_stall();
      // 11, 22 enter; two stall edges with junk inputs; then 33 and drain.
      bit         en_t [8] = '{1, 1, 0, 0, 1, 1, 1, 1};
      bit         v_t  [8] = '{1, 1, 1, 1, 1, 0, 0, 0};
      logic [7:0] d_t  [8] = '{8'h11, 8'h22, 8'hEE, 8'hEE, 8'h33, 8'h5A, 8'h5A, 8'h5A};
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b0, en_t[i], v_t[i], d_t[i]);
         n_tests++;
         if (obs_vec !== model_vec()) begin
            n_fail++;
            $display("FAIL stall edge %0d: observed %h required %h", i + 1, obs_vec, model_vec());
         end
      end
      n_tests++;
      if (a_sc !== (STATS ? 16'd2 : 16'd0)) begin
         n_fail++;
         $display("FAIL stall count: observed %0d required %0d", a_sc, STATS ? 2 : 0);
      end
   endtask

   task automatic test_flush_vs_stall();
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 8'(8'h80 + i));
      step(1'b0, 1'b1, 1'b0, 1'b1, 8'h77);
      n_tests++;
      if ({a_vo, a_do, b_vo, b_do} !== 18'h0) begin
         n_fail++;
         $display("FAIL flush kill: observed %h required 0", {a_vo, a_do, b_vo, b_do});
      end
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 1'b1, 1'b0, 8'h77);
         n_tests++;
         if (obs_vec !== model_vec() || a_do === 8'h77) begin
            n_fail++;
            $display("FAIL flush drain %0d: observed %h required %h", i, obs_vec, model_vec());
         end
      end
   endtask

   task automatic test_invalid_mask();
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 8'(8'hC0 + i));
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 1'b1, 1'b0, 8'hA5);
         n_tests++;
         if (obs_vec !== model_vec()) begin
            n_fail++;
            $display("FAIL invalid mask edge %0d: observed %h required %h", i, obs_vec, model_vec());
         end
      end
      n_tests++;
      if ({a_vo, a_do} !== 9'h000) begin
         n_fail++;
         $display("FAIL invalid mask output: observed %b/%h required 0/00", a_vo, a_do);
      end
   endtask

   task automatic test_saturation();
      logic [1:0] sat_t [6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 1'b0, 1'b0, 1'b1, 8'h99);
         n_tests++;
         if (b_sc !== (STATS ? sat_t[i] : 2'd0) || obs_vec !== model_vec()) begin
            n_fail++;
            $display("FAIL saturation stall %0d: observed %0d required %0d", i + 1, b_sc,
                     STATS ? sat_t[i] : 2'd0);
         end
      end
   endtask

   task automatic test_random();
      bit r, f, e, v;
      for (int i = 0; i < 300; i++) begin
         r = ($urandom_range(0, 49) == 0);
         f = ($urandom_range(0, 9) == 0);
         e = ($urandom_range(0, 3) != 0);
         v = ($urandom_range(0, 1) == 1);
         step(r, f, e, v, 8'($urandom));
         n_tests++;
         if (obs_vec !== model_vec()) begin
            n_fail++;
            $display("FAIL random step %0d: observed %h required %h", i, obs_vec, model_vec());
         end
         n_tests++;
         if ((!a_vo && a_do !== 8'h00) || (!b_vo && b_do !== 8'h00)) begin
            n_fail++;
            $display("FAIL bubble invariant step %0d: observed %h/%h required 00 when invalid",
                     i, a_do, b_do);
         end
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_stall();
      test_flush_vs_stall();
      test_invalid_mask();
      test_saturation();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
